uart_rx_cmd_parser: RTL and testbench
=====================================

// Module: uart_rx_cmd_parser
// PURPOSE
//  Consumes the byte stream produced by the UART receiver (Uart_Rx) and assembles command frames.
//  Write frame: WR_CMD, address byte, data byte. Read frame: RD_CMD, address byte.
//  Issues one-cycle register-file write/read strobes to the system controller.
//  Drops frames on receive errors, bad addresses or inter-byte timeout.
// PARAMETERS
//  width    8       UART data width; also the width of the address and data bytes
//  ADDR_W   4       register address width; upper width-ADDR_W address bits must be zero
//  WR_CMD   8'hAA   write command opcode
//  RD_CMD   8'hBB   read command opcode
//  TIMEOUT  4096    max CLK cycles allowed between bytes inside a frame (>=2)
// PORTS
//  CLK           in   1       system clock, same domain as the Uart_Rx outputs
//  Reset         in   1       asynchronous, active-low reset
//  Rx_data       in   width   received byte (Uart_Rx P_Data)
//  Rx_valid      in   1       one-cycle pulse: Rx_data valid
//  Parity_error  in   1       qualifies the current Rx_valid byte
//  stop_error    in   1       qualifies the current Rx_valid byte
//  Wr_EN         out  1       one-cycle write strobe
//  Rd_EN         out  1       one-cycle read strobe
//  Addr          out  ADDR_W  register address, valid while Wr_EN/Rd_EN is high
//  Wr_Data       out  width   write data, valid while Wr_EN is high
//  Frame_busy    out  1       high while the parser is not in IDLE
//  Frame_error   out  1       one-cycle pulse when a frame is dropped
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-frame discards the frame silently.
//  Byte acceptance: a byte is accepted only in a cycle where Rx_valid=1.
//  Bad byte: Parity_error or stop_error high with Rx_valid makes the byte bad.
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR.
//  IDLE:
//   - good byte == WR_CMD -> WR_ADDR.
//   - good byte == RD_CMD -> RD_ADDR.
//   - any other good byte: ignored, no error.
//   - bad byte: ignored, no error.
//  WR_ADDR / RD_ADDR, good byte with upper bits zero:
//   - latch Addr.
//   - WR_ADDR -> WR_DATA.
//   - RD_ADDR -> IDLE, with Rd_EN=1 in the next cycle.
//   - upper address bits nonzero: Frame_error pulse, -> IDLE.
//  WR_DATA, good byte: latch Wr_Data; Wr_EN=1 in the next cycle; -> IDLE.
//  Any non-IDLE state, bad byte: Frame_error pulse next cycle, -> IDLE, no strobe.
//  Latency: strobes and Frame_error are registered and appear exactly 1 CLK after the triggering Rx_valid cycle. Each is high for exactly 1 cycle.
//  Addr/Wr_Data: hold their last latched value otherwise; never cleared except by reset.
//  Frame_busy: high in every non-IDLE state; registered, i.e. a function of current state.
//  Timeout counter: cleared in IDLE and on every accepted byte; increments each cycle in non-IDLE without Rx_valid.
//  Timeout abort: when the count reaches TIMEOUT-1 with no byte, the next cycle gives a Frame_error pulse and FSM -> IDLE.
//  Simultaneous byte and timeout: Rx_valid in the expiry cycle wins; the byte is processed and the counter cleared.
//  Back-to-back frames: a new WR_CMD/RD_CMD arriving in the cycle the strobe is high is accepted normally. No bubble is required.
//  Counter width: $clog2(TIMEOUT); saturating logic is not needed because expiry forces IDLE.
// STRUCTURE
//  Package uart_cmd_pkg holds:
//   - state enum/localparams (IDLE=2'b00, WR_ADDR=2'b01, WR_DATA=2'b10, RD_ADDR=2'b11);
//   - default WR_CMD/RD_CMD opcode constants, shared with the Tx response formatter.
//  One sub-module: uart_frame_timer. It contains the timeout counter with clear/enable inputs and an expire output.
//  FSM, address check and output registers remain in this module.
// TESTING
//  1. Write frame: Rx bytes AA,05,3C with 20-cycle gaps -> one Wr_EN pulse, Addr=5, Wr_Data=3C, 1 cycle after 3rd Rx_valid; Rd_EN never high.
//  2. Read frame: BB,0A -> Rd_EN pulse with Addr=A, 1 cycle after 2nd byte; Frame_busy high from after BB until IDLE.
//  3. Errors:
//   - AA,05 then 3C with Parity_error=1 -> Frame_error pulse, no Wr_EN.
//   - A following AA,01,FF -> normal write Addr=1, Wr_Data=FF.
//   - Garbage byte 55 in IDLE -> no outputs.
//  4. Bad address: AA,25 (upper nibble nonzero, ADDR_W=4) -> Frame_error after 2nd byte; the next byte 3C is ignored in IDLE.
//  5. Timeout (TIMEOUT=16):
//   - AA then silence -> Frame_error 16 cycles later, Frame_busy drops.
//   - Rx_valid landing exactly on the expiry cycle -> byte accepted, no error.
//  6. Reset: assert Reset low after AA,05 -> outputs 0 immediately. After release, 3C alone produces no Wr_EN.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: parser state encoding and
// the default command opcodes also used by the Tx response formatter.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WR_ADDR = 2'b01,
      WR_DATA = 2'b10,
      RD_ADDR = 2'b11
   } state_e;

   localparam logic [7:0] DEF_WR_CMD = 8'hAA;
   localparam logic [7:0] DEF_RD_CMD = 8'hBB;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts idle cycles inside a frame and flags
// expiry in the cycle the count sits at TIMEOUT-1 with no byte arriving.
module uart_frame_timer #(
   parameter int TIMEOUT = 4096
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int                CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_clear)
         r_count <= '0;
      else if (i_enable)
         r_count <= r_count + CNT_W'(1);
   end

   // No wrap handling: expiry always sends the parser to IDLE, which clears us.
   assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Assembles write (WR_CMD, addr, data) and read (RD_CMD, addr) frames from
// the Uart_Rx byte stream and issues one-cycle register-file strobes.
module uart_rx_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int               width   = 8,
   parameter int               ADDR_W  = 4,
   parameter logic [width-1:0] WR_CMD  = width'(DEF_WR_CMD),
   parameter logic [width-1:0] RD_CMD  = width'(DEF_RD_CMD),
   parameter int               TIMEOUT = 4096
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [width-1:0]  Rx_data,
   input  logic              Rx_valid,
   input  logic              Parity_error,
   input  logic              stop_error,
   output logic              Wr_EN,
   output logic              Rd_EN,
   output logic [ADDR_W-1:0] Addr,
   output logic [width-1:0]  Wr_Data,
   output logic              Frame_busy,
   output logic              Frame_error
);

   state_e             r_state,   w_state_nxt;
   logic               r_wr_en,   w_wr_en_nxt;
   logic               r_rd_en,   w_rd_en_nxt;
   logic               r_err,     w_err_nxt;
   logic [ADDR_W-1:0]  r_addr,    w_addr_nxt;
   logic [width-1:0]   r_wr_data, w_wr_data_nxt;

   logic w_good, w_bad, w_addr_ok, w_tmr_clear, w_expire;

   assign w_good      = Rx_valid && !Parity_error && !stop_error;
   assign w_bad       = Rx_valid && (Parity_error || stop_error);
   assign w_addr_ok   = ((Rx_data >> ADDR_W) == '0);
   // Any arriving byte restarts the gap count; a byte in the expiry cycle wins.
   assign w_tmr_clear = (r_state == IDLE) || Rx_valid;

   uart_frame_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk    (CLK),
      .i_rst_n  (Reset),
      .i_clear  (w_tmr_clear),
      .i_enable (!w_tmr_clear),
      .o_expire (w_expire)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_en_nxt   = 1'b0;
      w_rd_en_nxt   = 1'b0;
      w_err_nxt     = 1'b0;
      w_addr_nxt    = r_addr;
      w_wr_data_nxt = r_wr_data;

      case (r_state)
         IDLE: begin
            if (w_good && Rx_data == WR_CMD)
               w_state_nxt = WR_ADDR;
            else if (w_good && Rx_data == RD_CMD)
               w_state_nxt = RD_ADDR;
         end

         WR_ADDR, RD_ADDR: begin
            if (w_bad || (w_good && !w_addr_ok) || w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_good) begin
               w_addr_nxt  = Rx_data[ADDR_W-1:0];
               w_rd_en_nxt = (r_state == RD_ADDR);
               w_state_nxt = (r_state == WR_ADDR) ? WR_DATA : IDLE;
            end
         end

         WR_DATA: begin
            if (w_bad || w_expire) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_good) begin
               w_wr_data_nxt = Rx_data;
               w_wr_en_nxt   = 1'b1;
               w_state_nxt   = IDLE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: Addr/Wr_Data are plain data registers but are still reset, since
   // they drive ports that must read 0 out of reset.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state   <= IDLE;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_rd_en   <= w_rd_en_nxt;
         r_err     <= w_err_nxt;
         r_addr    <= w_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
      end
   end

   assign Wr_EN       = r_wr_en;
   assign Rd_EN       = r_rd_en;
   assign Frame_error = r_err;
   assign Addr        = r_addr;
   assign Wr_Data     = r_wr_data;
   assign Frame_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Self-checking bench for uart_rx_cmd_parser: a scoreboard queue holds the
// strobe/error events expected per byte; a negedge monitor pops and compares.
module tb_uart_rx_cmd_parser;

   localparam int TOUT = 16;

   typedef enum logic [1:0] {EV_NONE, EV_WR, EV_RD, EV_ERR} ev_e;
   typedef struct {
      ev_e        kind;
      int         cyc;
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic [7:0] Rx_data = '0;
   logic       Rx_valid = 1'b0;
   logic       Parity_error = 1'b0;
   logic       stop_error = 1'b0;
   logic       Wr_EN, Rd_EN, Frame_busy, Frame_error;
   logic [3:0] Addr;
   logic [7:0] Wr_Data;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [2:0] mon_vec;

   uart_rx_cmd_parser #(
      .width(8), .ADDR_W(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT(TOUT)
   ) dut (
      .CLK(CLK), .Reset(Reset), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
      .Parity_error(Parity_error), .stop_error(stop_error),
      .Wr_EN(Wr_EN), .Rd_EN(Rd_EN), .Addr(Addr), .Wr_Data(Wr_Data),
      .Frame_busy(Frame_busy), .Frame_error(Frame_error)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: every strobe/error cycle must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (Reset && (Wr_EN || Rd_EN || Frame_error)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got wr=%b rd=%b err=%b at cyc %0d, required no event",
                     Wr_EN, Rd_EN, Frame_error, cyc);
         end else begin
            mon_e   = sb.pop_front();
            mon_vec = (mon_e.kind == EV_WR) ? 3'b100 :
                      (mon_e.kind == EV_RD) ? 3'b010 : 3'b001;
            if ({Wr_EN, Rd_EN, Frame_error} !== mon_vec) begin
               errors++;
               $display("FAIL event_kind: got wr/rd/err=%b, required %b", {Wr_EN, Rd_EN, Frame_error}, mon_vec);
            end
            checks++;
            if (cyc !== mon_e.cyc) begin
               errors++;
               $display("FAIL event_latency: got cyc %0d, required cyc %0d", cyc, mon_e.cyc);
            end
            if (mon_e.kind != EV_ERR) begin
               checks++;
               if (Addr !== mon_e.addr) begin
                  errors++;
                  $display("FAIL addr: got %h, required %h", Addr, mon_e.addr);
               end
            end
            if (mon_e.kind == EV_WR) begin
               checks++;
               if (Wr_Data !== mon_e.data) begin
                  errors++;
                  $display("FAIL wr_data: got %h, required %h", Wr_Data, mon_e.data);
               end
            end
         end
      end
   end

   // Drives one byte for one cycle; kind != EV_NONE queues the event the
   // byte must trigger one cycle after its Rx_valid cycle.
   task automatic send_byte(input logic [7:0] d, input logic pe = 1'b0, input logic se = 1'b0,
                            input ev_e kind = EV_NONE, input logic [3:0] a = '0,
                            input logic [7:0] wd = '0);
      exp_t e;
      @(negedge CLK);
      Rx_data = d; Rx_valid = 1'b1; Parity_error = pe; stop_error = se;
      if (kind != EV_NONE) begin
         e.kind = kind; e.cyc = cyc + 1; e.addr = a; e.data = wd;
         sb.push_back(e);
      end
      @(posedge CLK);
      #1;
      Rx_valid = 1'b0; Parity_error = 1'b0; stop_error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
   endtask

   // Bounded wait for all queued events, then require the queue empty.
   task automatic drain(input string name);
      int guard = 0;
      repeat (3) @(posedge CLK);
      while (sb.size() != 0 && guard < 40) begin
         @(posedge CLK);
         guard++;
      end
      @(negedge CLK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_events: got %0d events pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_busy(input string name, input logic exp);
      checks++;
      if (Frame_busy !== exp) begin
         errors++;
         $display("FAIL %s_busy: got %b, required %b", name, Frame_busy, exp);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({Wr_EN, Rd_EN, Frame_error, Frame_busy, Addr, Wr_Data} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 0",
                  {Wr_EN, Rd_EN, Frame_error, Frame_busy, Addr, Wr_Data});
      end
      idle(3);
      @(negedge CLK);
      Reset = 1'b1;
      idle(2);
   endtask

   task automatic test_write();
      // Gaps stay below TIMEOUT so the frame completes.
      send_byte(8'hAA);
      idle(12);
      send_byte(8'h05);
      idle(12);
      send_byte(8'h3C, 1'b0, 1'b0, EV_WR, 4'h5, 8'h3C);
      drain("write");
   endtask

   task automatic test_read();
      send_byte(8'hBB);
      @(negedge CLK);
      check_busy("read_mid", 1'b1);
      send_byte(8'h0A, 1'b0, 1'b0, EV_RD, 4'hA);
      @(negedge CLK);
      check_busy("read_end", 1'b0);
      drain("read");
   endtask

   task automatic test_errors();
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h3C, 1'b1, 1'b0, EV_ERR);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'hFF, 1'b0, 1'b0, EV_WR, 4'h1, 8'hFF);
      drain("err_recover");
      send_byte(8'hBB);
      send_byte(8'h02, 1'b0, 1'b1, EV_ERR);
      send_byte(8'h55);
      @(negedge CLK);
      check_busy("garbage", 1'b0);
      send_byte(8'hAA, 1'b1, 1'b0);
      @(negedge CLK);
      check_busy("bad_cmd", 1'b0);
      drain("garbage");
   endtask

   task automatic test_bad_addr();
      send_byte(8'hAA);
      send_byte(8'h25, 1'b0, 1'b0, EV_ERR);
      send_byte(8'h3C);
      @(negedge CLK);
      check_busy("bad_addr", 1'b0);
      drain("bad_addr");
   endtask

   task automatic test_timeout();
      exp_t e;
      send_byte(8'hAA);
      e.kind = EV_ERR; e.cyc = cyc + TOUT; e.addr = '0; e.data = '0;
      sb.push_back(e);
      idle(TOUT - 2);
      @(negedge CLK);
      check_busy("tout_before", 1'b1);
      idle(3);
      @(negedge CLK);
      check_busy("tout_after", 1'b0);
      drain("timeout");
      // Byte lands in the expiry cycle: it wins, then the frame completes.
      send_byte(8'hAA);
      idle(TOUT - 1);
      send_byte(8'h07);
      idle(TOUT - 1);
      send_byte(8'h99, 1'b0, 1'b0, EV_WR, 4'h7, 8'h99);
      drain("tout_edge");
   endtask

   task automatic test_back_to_back();
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h77, 1'b0, 1'b0, EV_WR, 4'h3, 8'h77);
      send_byte(8'hBB);
      send_byte(8'h0C, 1'b0, 1'b0, EV_RD, 4'hC);
      send_byte(8'hAA);
      send_byte(8'h0F);
      send_byte(8'h00, 1'b0, 1'b0, EV_WR, 4'hF, 8'h00);
      drain("b2b");
   endtask

   task automatic test_reset_midframe();
      send_byte(8'hAA);
      send_byte(8'h05);
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      checks++;
      if ({Wr_EN, Rd_EN, Frame_error, Frame_busy, Addr, Wr_Data} !== 16'h0) begin
         errors++;
         $display("FAIL midframe_reset_outputs: got %b, required 0",
                  {Wr_EN, Rd_EN, Frame_error, Frame_busy, Addr, Wr_Data});
      end
      idle(2);
      @(negedge CLK);
      Reset = 1'b1;
      send_byte(8'h3C);
      @(negedge CLK);
      check_busy("after_reset", 1'b0);
      drain("reset_midframe");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_errors();
      test_bad_addr();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit, required test completion");
      $fatal(1);
   end

endmodule
